// File: rtl/port_bp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : port_bp_fifo
// Description : Elastic buffer for one router port. Valid/backpressure
//               handshake on both sides, single clock. Registered output
//               stage, registered upstream backpressure with a free-word
//               margin (SLACK) so the sender may keep issuing words after
//               D_BP rises without loss.
//               Optional statistics outputs (LEVEL, OVERFLOW) are built when
//               the macro PORT_BP_FIFO_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module port_bp_fifo #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int SLACK     = 6     // legal range 2 .. 2**ADDR_BITS-1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_BP,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_BP
`ifdef PORT_BP_FIFO_STAT_EN
    ,
    output logic [ADDR_BITS:0] LEVEL,
    output logic               OVERFLOW
`endif
);

    localparam int                 c_depth_int = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] c_depth     = (ADDR_BITS+1)'(c_depth_int);
    localparam logic [ADDR_BITS:0] c_bp_thresh = (ADDR_BITS+1)'(c_depth_int - SLACK);
    localparam logic [ADDR_BITS:0] c_ptr_one   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0] c_ptr_zero  = '0;

    // Storage; contents are never reset, the pointers define what is valid.
    logic [WIDTH-1:0]   r_mem [0:c_depth_int-1];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [ADDR_BITS:0] r_wp;
    logic [ADDR_BITS:0] r_rp;

    logic [WIDTH-1:0]   r_q;
    logic               r_q_valid;
    logic               r_d_bp;

    logic [ADDR_BITS:0] w_count;
    logic [ADDR_BITS:0] w_count_next;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_issue;

    // Occupancy is the pointer distance; wrap of both pointers is natural.
    assign w_count = r_wp - r_rp;
    assign w_full  = (w_count == c_depth);
    assign w_empty = (w_count == c_ptr_zero);

    // Full is judged on the current count, so a same-cycle read never makes
    // room for a write. An empty FIFO never issues, so there is no bypass.
    assign w_wr    = D_VALID && !w_full;
    assign w_issue = !w_empty && !Q_BP;

    // Occupancy after this cycle's accepted write and issue.
    assign w_count_next = w_count
                        + {{ADDR_BITS{1'b0}}, w_wr}
                        - {{ADDR_BITS{1'b0}}, w_issue};

    // Write port into the storage array.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wp[ADDR_BITS-1:0]] <= D;
        end
    end

    // Pointer update; reset discards any stored words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp <= c_ptr_zero;
            r_rp <= c_ptr_zero;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_issue) begin
                r_rp <= r_rp + c_ptr_one;
            end
        end
    end

    // Registered output stage; Q holds its last value while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= w_issue;
            if (w_issue) begin
                r_q <= r_mem[r_rp[ADDR_BITS-1:0]];
            end
        end
    end

    // Upstream backpressure, registered from next-cycle occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_d_bp <= 1'b0;
        end else begin
            r_d_bp <= (w_count_next >= c_bp_thresh);
        end
    end

    assign Q       = r_q;
    assign Q_VALID = r_q_valid;
    assign D_BP    = r_d_bp;

`ifdef PORT_BP_FIFO_STAT_EN
    logic [ADDR_BITS:0] r_level;
    logic               r_overflow;

    // Registered fill level and sticky drop flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level    <= c_ptr_zero;
            r_overflow <= 1'b0;
        end else begin
            r_level <= w_count_next;
            if (D_VALID && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign LEVEL    = r_level;
    assign OVERFLOW = r_overflow;
`endif

endmodule
`default_nettype wire
